// File: rtl/gp_dram_pkg.sv
`timescale 1ns/1ps
// gp_dram_pkg
// Shared definitions for the graphics DRAM arbiter. It holds the command
// encodings, the burst geometry and the address-FIFO word layout
// {cmd[2:0], addr[27:0]}. It also holds the arbiter state type and a helper
// that packs an address-FIFO word.
package gp_dram_pkg;

    localparam logic [2:0] CMD_WRITE   = 3'b000;
    localparam logic [2:0] CMD_READ    = 3'b001;

    localparam int DRAM_BEAT_W = 128;
    localparam int DRAM_MASK_W = DRAM_BEAT_W / 8;
    localparam int BURST_BEATS = 2;

    // Address FIFO word layout: command in the top bits, word address below.
    localparam int AF_CMD_W    = 3;
    localparam int AF_ADDR_W   = 28;
    localparam int AF_W        = AF_CMD_W + AF_ADDR_W;
    localparam int AF_CMD_LSB  = AF_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WR1   = 2'b10
    } arb_state_t;

    function automatic logic [AF_W-1:0] af_pack(input logic [AF_CMD_W-1:0]  cmd,
                                                input logic [AF_ADDR_W-1:0] addr);
        return {cmd, addr};
    endfunction

endpackage

// File: rtl/gp_arb_tag_fifo.sv
`timescale 1ns/1ps
// gp_arb_tag_fifo
// This is an in-order FIFO of client indices, one entry per outstanding read
// burst. Pushing and popping in the same cycle are both honoured. A push
// while full and a pop while empty are ignored.
// Ports: clk, rst_n (async active-low); i_push/i_push_data; i_pop;
//        o_full (DEPTH entries held), o_empty, o_head (oldest entry).
module gp_arb_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == {(PW+1){1'b0}});
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array, pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{PW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{PW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gp_dram_arbiter.sv
`timescale 1ns/1ps
// gp_dram_arbiter
// This module shares one DRAM controller port among NUM_REQ graphics clients.
// Requests are granted round-robin. A read issues one address-FIFO push. A
// write issues one address push together with write beat 0, and pushes
// beat 1 on the next free cycle. Read bursts of two beats come back through
// an in-order tag FIFO to the client that issued them.
// Ports: req_* are per-client request inputs and req_ready pulses on accept.
//        rd_valid and rd_data carry read-return beats.
//        af_* is the address FIFO, wdf_* the write-data FIFO and rdf_* the
//        read-data FIFO.
// All outputs are combinational from state, grant and FIFO flags, and are 0
// whenever they are not actively driving.
module gp_dram_arbiter
    import gp_dram_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int TAG_DEPTH = 8,
    parameter int ADDR_W    = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*256-1:0]  req_wdata,
    input  logic [NUM_REQ*32-1:0]   req_wmask,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [127:0]            rd_data,
    input  logic                    af_full,
    output logic                    af_wr_en,
    output logic [30:0]             af_addr_din,
    input  logic                    wdf_full,
    output logic                    wdf_wr_en,
    output logic [127:0]            wdf_din,
    output logic [15:0]             wdf_mask_din,
    input  logic                    rdf_valid,
    input  logic [127:0]            rdf_dout,
    output logic                    rdf_rd_en
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] w_grant_nxt;
    logic [GW-1:0] r_rr_ptr;
    logic [GW-1:0] w_rr_nxt;
    logic [GW-1:0] w_arb_idx;
    logic [GW-1:0] w_grant_inc;
    logic          r_beat;

    logic                    w_sel_write;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [255:0]            w_sel_wdata;
    logic [31:0]             w_sel_wmask;
    logic [NUM_REQ-1:0]      w_grant_onehot;
    logic [NUM_REQ-1:0]      w_head_onehot;

    logic          w_tag_push;
    logic          w_tag_pop;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic [GW-1:0] w_tag_head;

    assign w_sel_write = req_write[r_grant];
    assign w_sel_addr  = req_addr[int'(r_grant)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[int'(r_grant)*256 +: 256];
    assign w_sel_wmask = req_wmask[int'(r_grant)*32 +: 32];
    assign w_grant_inc = (r_grant == GW'(NUM_REQ-1)) ? {GW{1'b0}} : (r_grant + GW'(1));

    gp_arb_tag_fifo #(
        .W     (GW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_tag_push),
        .i_push_data (r_grant),
        .i_pop       (w_tag_pop),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_head      (w_tag_head)
    );

    // Round-robin search: find the first valid client at or after rr_ptr, wrapping around.
    always_comb begin : arb_search
        int   v_idx;
        logic v_found;
        w_arb_idx = r_rr_ptr;
        v_found   = 1'b0;
        v_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end else begin
                v_idx = v_idx;
            end
            if (!v_found && req_valid[v_idx]) begin
                w_arb_idx = GW'(v_idx);
                v_found   = 1'b1;
            end else begin
                v_found   = v_found;
            end
        end
    end

    // One-hot decodes of the current grant and of the tag FIFO head.
    always_comb begin
        w_grant_onehot = {NUM_REQ{1'b0}};
        w_head_onehot  = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_onehot[i] = (r_grant == GW'(i));
            w_head_onehot[i]  = (w_tag_head == GW'(i));
        end
    end

    // Request FSM: compute the next state and drive the issue-side outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_nxt     = r_rr_ptr;
        w_tag_push   = 1'b0;
        af_wr_en     = 1'b0;
        af_addr_din  = {AF_W{1'b0}};
        wdf_wr_en    = 1'b0;
        wdf_din      = {DRAM_BEAT_W{1'b0}};
        wdf_mask_din = {DRAM_MASK_W{1'b0}};
        req_ready    = {NUM_REQ{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_grant_nxt = w_arb_idx;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_sel_write) begin
                    if (!af_full && !wdf_full) begin
                        af_wr_en     = 1'b1;
                        af_addr_din  = af_pack(CMD_WRITE, AF_ADDR_W'(w_sel_addr));
                        wdf_wr_en    = 1'b1;
                        wdf_din      = w_sel_wdata[127:0];
                        wdf_mask_din = w_sel_wmask[15:0];
                        req_ready    = w_grant_onehot;
                        w_rr_nxt     = w_grant_inc;
                        w_state_nxt  = ST_WR1;
                    end else begin
                        w_state_nxt  = ST_ISSUE;
                    end
                end else begin
                    // A read also needs a free tag slot so that its return can be steered.
                    if (!af_full && !w_tag_full) begin
                        af_wr_en    = 1'b1;
                        af_addr_din = af_pack(CMD_READ, AF_ADDR_W'(w_sel_addr));
                        req_ready   = w_grant_onehot;
                        w_tag_push  = 1'b1;
                        w_rr_nxt    = w_grant_inc;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_WR1: begin
                // The client is still holding its wdata, so beat 1 comes straight from the request bus.
                if (!wdf_full) begin
                    wdf_wr_en    = 1'b1;
                    wdf_din      = w_sel_wdata[255:128];
                    wdf_mask_din = w_sel_wmask[31:16];
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt  = ST_WR1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read return path: pop a beat when there is data and a tag to steer it to.
    always_comb begin
        rdf_rd_en = rdf_valid && !w_tag_empty;
        if (rdf_rd_en) begin
            rd_valid = w_head_onehot;
            rd_data  = rdf_dout;
        end else begin
            rd_valid = {NUM_REQ{1'b0}};
            rd_data  = {DRAM_BEAT_W{1'b0}};
        end
        // The tag retires with the second beat of its burst.
        w_tag_pop = rdf_rd_en && r_beat;
    end

    // State, grant, round-robin pointer and return beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= {GW{1'b0}};
            r_rr_ptr <= {GW{1'b0}};
            r_beat   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
            if (rdf_rd_en) begin
                r_beat <= ~r_beat;
            end else begin
                r_beat <= r_beat;
            end
        end
    end

endmodule

// File: tb/tb_gp_dram_arbiter.sv
`timescale 1ns/1ps
module tb_gp_dram_arbiter;

    localparam int N  = 3;
    localparam int AW = 28;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_addr  = '0;
    logic [N*256-1:0]  req_wdata = '0;
    logic [N*32-1:0]   req_wmask = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rd_valid;
    logic [127:0]      rd_data;
    logic              af_full = 1'b0;
    logic              af_wr_en;
    logic [30:0]       af_addr_din;
    logic              wdf_full = 1'b0;
    logic              wdf_wr_en;
    logic [127:0]      wdf_din;
    logic [15:0]       wdf_mask_din;
    logic              rdf_valid = 1'b0;
    logic [127:0]      rdf_dout = '0;
    logic              rdf_rd_en;

    gp_dram_arbiter #(.NUM_REQ(N), .TAG_DEPTH(8), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .af_full(af_full), .af_wr_en(af_wr_en), .af_addr_din(af_addr_din),
        .wdf_full(wdf_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
        .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 = waiting to grant, 1 = granted and trying to issue, 2 = write beat 1 pending.
    int m_mode = 0, m_grant = 0, m_rr = 0, m_beat = 0;
    int m_tags[$];
    int n_mode, n_grant, n_rr, n_beat, n_push_val;
    bit n_push, n_pop;

    logic [N-1:0] e_rdy, e_rdv;
    logic e_af, e_wdf, e_rdfen;
    logic [30:0] e_afd;
    logic [127:0] e_wd, e_rd;
    logic [15:0] e_wm;

    // event logs of what the DUT did, used by the directed literal checks
    int af_cyc[$];  logic [30:0] af_val[$];
    int wdf_cyc[$]; logic [127:0] wdf_val[$]; logic [15:0] wdf_msk[$];
    logic [N-1:0] rdy_val[$];
    int rd_cyc[$];  logic [N-1:0] rdv_val[$]; logic [127:0] rdd_val[$];

    task automatic clear_logs();
        af_cyc.delete(); af_val.delete(); wdf_cyc.delete(); wdf_val.delete(); wdf_msk.delete();
        rdy_val.delete(); rd_cyc.delete(); rdv_val.delete(); rdd_val.delete();
    endtask

    always @(negedge clk) begin
        int g;
        e_rdy = '0; e_rdv = '0; e_af = 1'b0; e_wdf = 1'b0; e_rdfen = 1'b0;
        e_afd = '0; e_wd = '0; e_rd = '0; e_wm = '0;
        n_mode = m_mode; n_grant = m_grant; n_rr = m_rr; n_beat = m_beat;
        n_push = 1'b0; n_pop = 1'b0; n_push_val = 0;
        g = m_grant;
        if (rst_n) begin
            if (m_mode == 0) begin
                if (req_valid != '0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req_valid[(m_rr + k) % N]) n_grant = (m_rr + k) % N;
                    n_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (req_write[g]) begin
                    if (!af_full && !wdf_full) begin
                        e_af = 1'b1; e_afd = {3'b000, req_addr[g*AW +: AW]};
                        e_wdf = 1'b1; e_wd = req_wdata[g*256 +: 128]; e_wm = req_wmask[g*32 +: 16];
                        e_rdy[g] = 1'b1; n_rr = (g + 1) % N; n_mode = 2;
                    end
                end else if (!af_full && m_tags.size() < 8) begin
                    e_af = 1'b1; e_afd = {3'b001, req_addr[g*AW +: AW]};
                    e_rdy[g] = 1'b1; n_rr = (g + 1) % N; n_mode = 0;
                    n_push = 1'b1; n_push_val = g;
                end
            end else begin
                if (!wdf_full) begin
                    e_wdf = 1'b1; e_wd = req_wdata[g*256 + 128 +: 128]; e_wm = req_wmask[g*32 + 16 +: 16];
                    n_mode = 0;
                end
            end
            if (rdf_valid && m_tags.size() > 0) begin
                e_rdfen = 1'b1; e_rdv[m_tags[0]] = 1'b1; e_rd = rdf_dout;
                n_pop = (m_beat == 1); n_beat = 1 - m_beat;
            end
        end
        chk("req_ready", req_ready, e_rdy);
        chk("af_wr_en", af_wr_en, e_af);
        chk("af_addr_din", af_addr_din, e_afd);
        chk("wdf_wr_en", wdf_wr_en, e_wdf);
        chk("wdf_din", wdf_din, e_wd);
        chk("wdf_mask_din", wdf_mask_din, e_wm);
        chk("rdf_rd_en", rdf_rd_en, e_rdfen);
        chk("rd_valid", rd_valid, e_rdv);
        chk("rd_data", rd_data, e_rd);
        if (af_wr_en) begin af_cyc.push_back(cyc); af_val.push_back(af_addr_din); end
        if (wdf_wr_en) begin wdf_cyc.push_back(cyc); wdf_val.push_back(wdf_din); wdf_msk.push_back(wdf_mask_din); end
        if (req_ready != '0) rdy_val.push_back(req_ready);
        if (rd_valid != '0) begin rd_cyc.push_back(cyc); rdv_val.push_back(rd_valid); rdd_val.push_back(rd_data); end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_grant <= 0; m_rr <= 0; m_beat <= 0;
            m_tags.delete();
        end else begin
            m_mode <= n_mode; m_grant <= n_grant; m_rr <= n_rr; m_beat <= n_beat;
            if (n_pop) void'(m_tags.pop_front());
            if (n_push) m_tags.push_back(n_push_val);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Raise valid for client c, hold it until its ready pulse, and drop it one edge later.
    task automatic issue_req(input int c);
        bit seen = 1'b0;
        req_valid[c] = 1'b1;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk); #1;
            if (req_ready[c]) seen = 1'b1;
        end
        chk("ready_timeout", seen, 1'b1);
        tick();
        req_valid[c] = 1'b0;
    endtask

    task automatic wait_rdy(input int n);
        for (int t = 0; t < 100 && rdy_val.size() < n; t++) begin
            @(negedge clk); #1;
        end
        chk("wait_rdy_timeout", rdy_val.size() >= n, 1'b1);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_cyc;
        int gaps[5];
        logic [N-1:0] order[6];
        gaps = '{2, 3, 3, 2, 3};
        order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset state: every output is quiet.
        rdf_valid = 1'b1; rdf_dout = 128'hDEAD;
        tick(); tick();
        chk("rst_af", af_wr_en, 1'b0);
        chk("rst_rdf_rd_en", rdf_rd_en, 1'b0);
        chk("rst_rd_valid", rd_valid, 3'b000);
        rdf_valid = 1'b0; rdf_dout = '0;
        rst_n = 1'b1;
        tick();

        // 1: single read from client 0.
        req_addr[0*AW +: AW] = 28'h0000100;
        clear_logs();
        issue_req(0);
        tick();
        chk("s1_af_count", af_val.size(), 1);
        chk("s1_af_word", af_val[0], {3'b001, 28'h0000100});
        chk("s1_ready", rdy_val[0], 3'b001);
        rdf_valid = 1'b1; rdf_dout = 128'hAAAA_0001;
        tick();
        rdf_dout = 128'hBBBB_0002;
        tick();
        rdf_valid = 1'b0;
        chk("s1_rd_count", rdv_val.size(), 2);
        chk("s1_rd_v0", rdv_val[0], 3'b001);
        chk("s1_rd_v1", rdv_val[1], 3'b001);
        chk("s1_rd_d0", rdd_val[0], 128'hAAAA_0001);
        chk("s1_rd_d1", rdd_val[1], 128'hBBBB_0002);
        rdf_valid = 1'b1; #1;
        chk("s1_tag_empty", rdf_rd_en, 1'b0);
        rdf_valid = 1'b0;

        // 2: single write from client 1.
        req_write[1] = 1'b1;
        req_addr[1*AW +: AW] = 28'h0002000;
        req_wdata[1*256 +: 256] = {128'hB, 128'hA};
        req_wmask[1*32 +: 32] = 32'h0;
        clear_logs();
        issue_req(1);
        tick();
        chk("s2_af_word", af_val[0], {3'b000, 28'h0002000});
        chk("s2_wdf_count", wdf_val.size(), 2);
        chk("s2_wdf0", wdf_val[0], 128'hA);
        chk("s2_wdf1", wdf_val[1], 128'hB);
        chk("s2_wdf0_with_af", wdf_cyc[0], af_cyc[0]);
        chk("s2_wdf1_next", wdf_cyc[1], af_cyc[0] + 1);
        chk("s2_ready_count", rdy_val.size(), 1);
        chk("s2_ready", rdy_val[0], 3'b010);

        // 3: all three clients continuously from reset.
        do_reset();
        req_addr[0*AW +: AW] = 28'h0000300;
        req_write[2] = 1'b1;
        req_addr[2*AW +: AW] = 28'h0004000;
        req_wdata[2*256 +: 256] = {128'hC2_0001, 128'hC2_0000};
        req_wmask[2*32 +: 32] = 32'h0000_FFFF;
        clear_logs();
        req_valid = 3'b111;
        wait_rdy(6);
        req_valid = 3'b000;
        tick(); tick();
        for (int i = 0; i < 6; i++) chk("s3_grant_order", rdy_val[i], order[i]);
        for (int i = 0; i < 5; i++) chk("s3_af_gap", af_cyc[i+1] - af_cyc[i], gaps[i]);
        chk("s3_af_read", af_val[0], {3'b001, 28'h0000300});
        chk("s3_af_wr2", af_val[2], {3'b000, 28'h0004000});
        chk("s3_wdf_mask", wdf_msk[5], 16'h0000);
        rdf_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin rdf_dout = 128'h300 + j; tick(); end
        rdf_valid = 1'b0;
        chk("s3_rd_count", rdv_val.size(), 4);

        // 4: af_full held during ISSUE, then wdf_full held during WR1.
        clear_logs();
        af_full = 1'b1;
        req_valid[1] = 1'b1;
        tick();
        repeat (5) tick();
        chk("s4_no_af", af_val.size(), 0);
        chk("s4_no_ready", rdy_val.size(), 0);
        chk("s4_no_wdf", wdf_val.size(), 0);
        af_full = 1'b0;
        fall_cyc = cyc;
        tick();
        req_valid[1] = 1'b0;
        wdf_full = 1'b1;
        chk("s4_af_on_fall", af_cyc[0], fall_cyc);
        chk("s4_ready_once", rdy_val.size(), 1);
        repeat (3) tick();
        chk("s4_wdf_held", wdf_val.size(), 1);
        wdf_full = 1'b0;
        tick();
        chk("s4_wdf_count", wdf_val.size(), 2);
        chk("s4_wdf1", wdf_val[1], 128'hB);
        chk("s4_wdf1_cyc", wdf_cyc[1], wdf_cyc[0] + 4);

        // 5: nine reads from client 0 with no read data returning.
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            req_addr[0*AW +: AW] = 28'h0001000 + i;
            issue_req(0);
        end
        req_addr[0*AW +: AW] = 28'h0001008;
        req_valid[0] = 1'b1;
        repeat (5) tick();
        chk("s5_eight_accepted", rdy_val.size(), 8);
        chk("s5_ninth_blocked", af_val.size(), 8);
        rdf_valid = 1'b1;
        for (int j = 0; j < 18; j++) begin
            rdf_dout = 128'hD00 + j;
            tick();
            if (rdy_val.size() == 9) req_valid[0] = 1'b0;
        end
        rdf_valid = 1'b0;
        req_valid[0] = 1'b0;
        chk("s5_ninth_word", af_val[8], {3'b001, 28'h0001008});
        chk("s5_ninth_after_tag", af_cyc[8], rd_cyc[1] + 1);
        chk("s5_rd_count", rdd_val.size(), 18);
        for (int j = 0; j < 18; j++) chk("s5_rd_order", rdd_val[j], 128'hD00 + j);

        // 6: reset pulse in the middle of WR1.
        clear_logs();
        req_valid = 3'b110;
        wait_rdy(1);
        chk("s6_first_grant", rdy_val[0], 3'b010);
        req_valid[1] = 1'b0;
        wdf_full = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_af", af_wr_en, 1'b0);
        chk("s6_async_wdf", wdf_wr_en, 1'b0);
        chk("s6_async_ready", req_ready, 3'b000);
        tick(); tick();
        rst_n = 1'b1;
        wdf_full = 1'b0;
        clear_logs();
        req_valid = 3'b110;
        wait_rdy(1);
        chk("s6_regrant_from0", rdy_val[0], 3'b010);
        req_valid[1] = 1'b0;
        wait_rdy(2);
        chk("s6_client2", rdy_val[1], 3'b100);
        req_valid[2] = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
